// File: rtl/classifier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : classifier_pkg
//  Description : Shared types and helpers for the digit classifier: FSM
//                state encoding, default fractional width and the
//                most-negative-score helper used to seed the runner-up.
//  Revision    : 1.0 - initial release
// ============================================================================
package classifier_pkg;

  // FSM state encoding, fixed 2-bit width.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int FRAC_DEFAULT = 12;

  // Most-negative two's complement value of a bits-wide score, returned
  // sign-extended to 64 bits so callers can truncate to any width <= 64.
  function automatic logic [63:0] score_min(input int bits);
    return {64{1'b1}} << (bits - 1);
  endfunction

endpackage : classifier_pkg
`default_nettype wire

// File: rtl/digit_classifier_top2_update.sv
`default_nettype none
// ============================================================================
//  Module      : top2_update
//  Description : Combinational running top-2 update. Folds one candidate
//                score into the current (best, second, best_idx) triple using
//                strict signed compares, so ties favour the earlier index.
//  Ports       : i_best/i_second/i_best_idx - current triple
//                i_cand/i_idx               - candidate score and its index
//                o_best/o_second/o_best_idx - updated triple
//  Revision    : 1.0 - initial release
// ============================================================================
module top2_update #(
  parameter int BITS  = 24,
  parameter int IDX_W = 4
) (
  input  logic signed [BITS-1:0]  i_best,
  input  logic signed [BITS-1:0]  i_second,
  input  logic        [IDX_W-1:0] i_best_idx,
  input  logic signed [BITS-1:0]  i_cand,
  input  logic        [IDX_W-1:0] i_idx,
  output logic signed [BITS-1:0]  o_best,
  output logic signed [BITS-1:0]  o_second,
  output logic        [IDX_W-1:0] o_best_idx
);

  always_comb begin
    o_best     = i_best;
    o_second   = i_second;
    o_best_idx = i_best_idx;
    if (i_cand > i_best) begin
      // New leader: the old leader drops to runner-up.
      o_second   = i_best;
      o_best     = i_cand;
      o_best_idx = i_idx;
    end else if (i_cand > i_second) begin
      // An equal-to-best later score lands here, giving margin 0.
      o_second = i_cand;
    end
  end

endmodule : top2_update
`default_nettype wire

// File: rtl/digit_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : digit_classifier
//  Description : Final decision stage after the FC layer. On the rising edge
//                of layer_done it captures all HEIGHT scores, scans them one
//                per cycle for the best and second-best, then publishes the
//                winning digit, both scores, their margin and a
//                low-confidence flag alongside a one-cycle result_valid.
//  Ports       : clk, reset (async, active-high)
//                layer_done     - level done flag from the FC layer
//                layer_in       - HEIGHT packed signed scores, [i] = digit i
//                digit          - index of the highest score
//                best_score     - highest score
//                second_score   - second-highest score
//                margin         - best_score - second_score (unsigned)
//                low_confidence - margin < MARGIN_MIN
//                result_valid   - one-cycle pulse with updated results
//                busy           - capture edge through result_valid cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_classifier
  import classifier_pkg::*;
#(
  parameter int BITS       = 24,
  parameter int HEIGHT     = 10,
  parameter int FRAC       = FRAC_DEFAULT,
  parameter int MARGIN_MIN = 2048
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          layer_done,
  input  logic [HEIGHT-1:0][BITS-1:0]   layer_in,
  output logic [$clog2(HEIGHT)-1:0]     digit,
  output logic [BITS-1:0]               best_score,
  output logic [BITS-1:0]               second_score,
  output logic [BITS-1:0]               margin,
  output logic                          low_confidence,
  output logic                          result_valid,
  output logic                          busy
);

  localparam int                IDX_W          = $clog2(HEIGHT);
  localparam logic [IDX_W-1:0]  C_LAST_IDX     = IDX_W'(HEIGHT - 1);
  localparam logic [BITS-1:0]   C_SCORE_MIN    = BITS'(score_min(BITS));
  localparam logic [BITS-1:0]   C_MARGIN_MIN   = BITS'(MARGIN_MIN);

  // The fixed-point format must leave at least one integer/sign bit.
  generate
    if (FRAC >= BITS) begin : g_frac_check
      $error("digit_classifier: FRAC must be smaller than BITS");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e                         state_q, state_d;
  logic                           done_q, done_d;
  logic                           busy_q, busy_d;
  logic [HEIGHT-1:0][BITS-1:0]    score_buf_q, score_buf_d;
  logic signed [BITS-1:0]         best_q, best_d;
  logic signed [BITS-1:0]         second_q, second_d;
  logic [IDX_W-1:0]               best_idx_q, best_idx_d;
  logic [IDX_W-1:0]               idx_q, idx_d;

  logic [IDX_W-1:0]               digit_q, digit_d;
  logic [BITS-1:0]                best_score_q, best_score_d;
  logic [BITS-1:0]                second_score_q, second_score_d;
  logic [BITS-1:0]                margin_q, margin_d;
  logic                           low_conf_q, low_conf_d;
  logic                           result_valid_q, result_valid_d;

  logic                           w_trigger;
  logic signed [BITS-1:0]         w_cand;
  logic signed [BITS-1:0]         w_upd_best;
  logic signed [BITS-1:0]         w_upd_second;
  logic [IDX_W-1:0]               w_upd_idx;
  logic [BITS-1:0]                w_margin;

  assign w_trigger = layer_done & ~done_q;
  assign w_cand    = $signed(score_buf_q[idx_q]);

  // best >= second always holds, so the true difference is non-negative and
  // fits in BITS unsigned bits; the BITS-wide wrap-around subtraction yields
  // exactly those bits.
  assign w_margin  = best_q - second_q;

  top2_update #(
    .BITS  (BITS),
    .IDX_W (IDX_W)
  ) u_top2_update (
    .i_best     (best_q),
    .i_second   (second_q),
    .i_best_idx (best_idx_q),
    .i_cand     (w_cand),
    .i_idx      (idx_q),
    .o_best     (w_upd_best),
    .o_second   (w_upd_second),
    .o_best_idx (w_upd_idx)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    done_d         = layer_done;
    score_buf_d    = score_buf_q;
    best_d         = best_q;
    second_d       = second_q;
    best_idx_d     = best_idx_q;
    idx_d          = idx_q;
    digit_d        = digit_q;
    best_score_d   = best_score_q;
    second_score_d = second_score_q;
    margin_d       = margin_q;
    low_conf_d     = low_conf_q;
    result_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Triggers are only honoured here; edges during SCAN/OUT are dropped.
        if (w_trigger) begin
          score_buf_d = layer_in;
          best_d      = $signed(layer_in[0]);
          second_d    = $signed(C_SCORE_MIN);
          best_idx_d  = '0;
          idx_d       = IDX_W'(1);
          state_d     = SCAN;
        end
      end
      SCAN: begin
        best_d     = w_upd_best;
        second_d   = w_upd_second;
        best_idx_d = w_upd_idx;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == C_LAST_IDX) begin
          state_d = OUT;
        end
      end
      OUT: begin
        digit_d        = best_idx_q;
        best_score_d   = best_q;
        second_score_d = second_q;
        margin_d       = w_margin;
        low_conf_d     = (w_margin < C_MARGIN_MIN);
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy spans capture through the result_valid cycle; a capture in that
    // same cycle keeps it high for the next run.
    if (state_q == IDLE && w_trigger) begin
      busy_d = 1'b1;
    end else if (result_valid_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      best_q         <= '0;
      second_q       <= '0;
      best_idx_q     <= '0;
      idx_q          <= '0;
      digit_q        <= '0;
      best_score_q   <= '0;
      second_score_q <= '0;
      margin_q       <= '0;
      low_conf_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      best_q         <= best_d;
      second_q       <= second_d;
      best_idx_q     <= best_idx_d;
      idx_q          <= idx_d;
      digit_q        <= digit_d;
      best_score_q   <= best_score_d;
      second_score_q <= second_score_d;
      margin_q       <= margin_d;
      low_conf_q     <= low_conf_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Score buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    score_buf_q <= score_buf_d;
  end

  assign digit          = digit_q;
  assign best_score     = best_score_q;
  assign second_score   = second_score_q;
  assign margin         = margin_q;
  assign low_confidence = low_conf_q;
  assign result_valid   = result_valid_q;
  assign busy           = busy_q;

endmodule : digit_classifier
`default_nettype wire

// File: doc/digit_classifier.md
# digit_classifier

Final decision stage of the inference pipeline, directly downstream of the fully connected layer. It captures the HEIGHT signed fixed-point scores when that layer's done flag rises. It then scans them sequentially for the highest and second-highest score and reports the winning digit, both scores, their margin and a low-confidence flag, with a one-cycle valid pulse.

## Interface
Parameters:
- BITS, 24, score width; two's complement Q(BITS-FRAC).FRAC
- HEIGHT, 10, number of class scores (digits 0..HEIGHT-1)
- FRAC, 12, fractional bits (1.0 = 4096)
- MARGIN_MIN, 2048, margin below which low_confidence is set (0.5 in Q12)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - reset  in  1  asynchronous, active-high reset
- Inputs:
  - layer_done  in  1  level done flag from the FC layer; stays high once set
  - layer_in  in  BITS × [HEIGHT]  score array; element i is the score of digit i
- Outputs:
  - digit  out  $clog2(HEIGHT)  index of the highest score
  - best_score  out  BITS  highest score, signed
  - second_score  out  BITS  second-highest score, signed
  - margin  out  BITS  best_score − second_score, unsigned
  - low_confidence  out  1  margin < MARGIN_MIN
  - result_valid  out  1  one-cycle pulse; result outputs are updated in the same cycle
  - busy  out  1  high from the capture edge until the result_valid cycle, inclusive

## Operation
- Trigger is the rising edge of layer_done, detected as layer_done & ~done_q. done_q is registered and reset to 0.
- A level held high produces exactly one classification. Re-arming requires layer_done to go low, then high again.
- FSM states: IDLE, SCAN, OUT.
- IDLE → SCAN on trigger:
  - latch all layer_in into an internal buffer
  - best = buf[0], best_idx = 0, second = most-negative value (0x800000 for BITS = 24)
  - idx = 1; busy goes high
- SCAN, one element per cycle, signed compare of buf[idx]:
  - If buf[idx] > best: second = best; best = buf[idx]; best_idx = idx.
  - Else if buf[idx] > second: second = buf[idx].
  - Strict compares, so ties go to the lowest index. An equal later value becomes second, giving margin 0.
  - After idx = HEIGHT-1, go to OUT.
- OUT:
  - register digit, best_score, second_score, margin and low_confidence
  - result_valid = 1 for this cycle; busy stays high in this cycle
  - go to IDLE
- Result outputs hold their values until the next OUT or reset.
- margin: best ≥ second always, so the difference fits BITS unsigned bits. Computed as BITS+1-bit signed, low BITS taken; no saturation needed.
- A trigger edge seen while in SCAN or OUT is ignored and is not queued. done_q still tracks layer_done.
- layer_in changes after the capture edge have no effect on the result in progress.

## Timing
- Reset values:
  - all result outputs 0; result_valid 0; busy 0
  - FSM in IDLE; done_q 0; buffer contents don't-care
- Reset mid-operation aborts immediately. No result_valid is produced for the aborted run.
- If layer_done is already high at reset release, done_q = 0, so a trigger fires on the first clock edge. This is intended: one classification.
- Latency: capture on edge E; SCAN on edges E+1 .. E+HEIGHT-1; result_valid high in the cycle following edge E+HEIGHT. That is 10 cycles for HEIGHT = 10.
- Throughput: one classification per HEIGHT+1 cycles at most, gated by layer_done re-arm.

## Structure
- Package classifier_pkg holds:
  - state enum (IDLE, SCAN, OUT)
  - FRAC_DEFAULT = 12
  - function score_min(BITS) returning the most-negative value
- One natural sub-module: top2_update. It is combinational: takes best, second, best_idx, candidate and idx, and returns the updated triple. It is instantiated once inside the FSM datapath.
- Target size: about 150–200 lines of RTL including the package.

## Test plan
- Ascending scores, layer_in[i] = i·4096 → result_valid exactly 10 cycles after the edge; digit 9, best 36864, second 32768, margin 4096, low_confidence 0.
- Tie: layer_in[3] = layer_in[7] = 4096, others 0 → digit 3, best 4096, second 4096, margin 0, low_confidence 1.
- All negative, layer_in[i] = −4096·(i+1) → digit 0, best 0xFFF000, second 0xFFE000, margin 4096.
- Extremes: layer_in[5] = 0x7FFFFF, all others 0x800000 → digit 5, second 0x800000, margin 0xFFFFFF.
- layer_done held high for 50 cycles → exactly one result_valid pulse. Drop layer_done, change layer_in, raise it again → second pulse with the new result. An extra edge during SCAN is ignored.
- Reset asserted during the 5th SCAN cycle → all outputs 0 and busy 0 immediately; no result_valid. Release reset with layer_done low → stays idle.
